// File: rtl/bcd_len_counter.sv
// Packed-BCD tick counter with four selectable lengths and terminal-count clear.
// Length changes are deferred to the next wrap; a bar counter tallies wraps.
module bcd_len_counter #(
    parameter int                  DIGITS = 3,
    parameter logic [4*DIGITS-1:0] LEN0   = 12'h125,
    parameter logic [4*DIGITS-1:0] LEN1   = 12'h075,
    parameter logic [4*DIGITS-1:0] LEN2   = 12'h050,
    parameter logic [4*DIGITS-1:0] LEN3   = 12'h025,
    parameter int                  BAR_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                run,
    input  logic [1:0]          len_sel,
    output logic [4*DIGITS-1:0] cnt,
    output logic [1:0]          len_act,
    output logic                wrap,
    output logic [BAR_W-1:0]    bar,
    output logic                busy
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Any digit at 9 or above rolls to 0, so an illegal digit can never persist.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [W-1:0] TERM0 = bcd_dec(LEN0);
    localparam logic [W-1:0] TERM1 = bcd_dec(LEN1);
    localparam logic [W-1:0] TERM2 = bcd_dec(LEN2);
    localparam logic [W-1:0] TERM3 = bcd_dec(LEN3);

    logic [W-1:0] term;
    logic [W-1:0] cnt_next;
    logic         at_term;

    always_comb begin
        term = TERM0;
        unique case (len_act)
            2'd0: term = TERM0;
            2'd1: term = TERM1;
            2'd2: term = TERM2;
            2'd3: term = TERM3;
            default: term = TERM0;
        endcase
    end

    assign cnt_next = bcd_inc(cnt);
    assign at_term  = (cnt == term);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            len_act <= 2'd0;
            wrap    <= 1'b0;
            bar     <= '0;
            busy    <= 1'b0;
        end else if (!run) begin
            cnt     <= '0;
            len_act <= len_sel;
            wrap    <= 1'b0;
            bar     <= '0;
            busy    <= 1'b0;
        end else begin
            busy <= 1'b1;
            wrap <= 1'b0;
            if (tick) begin
                if (at_term) begin
                    cnt     <= '0;
                    wrap    <= 1'b1;
                    bar     <= bar + 1'b1;
                    len_act <= len_sel;
                end else begin
                    cnt <= cnt_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_len_counter.sv
// Self-checking bench for bcd_len_counter: vector table, directed corners,
// and randomized traffic against an integer-arithmetic reference model.
module tb_bcd_len_counter;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        run;
    logic [1:0]  len_sel;
    logic [11:0] cnt;
    logic [1:0]  len_act;
    logic        wrap;
    logic [3:0]  bar;
    logic        busy;

    logic [1:0]  len_sel_b;
    logic [11:0] cnt_b;
    logic [1:0]  len_act_b;
    logic        wrap_b;
    logic [3:0]  bar_b;
    logic        busy_b;

    bcd_len_counter dut (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .len_sel(len_sel),
        .cnt(cnt), .len_act(len_act), .wrap(wrap), .bar(bar), .busy(busy)
    );

    bcd_len_counter #(.LEN3(12'h001)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .len_sel(len_sel_b),
        .cnt(cnt_b), .len_act(len_act_b), .wrap(wrap_b), .bar(bar_b),
        .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: plain decimal state, converted to BCD only to compare.
    int lens[4] = '{125, 75, 50, 25};
    int m_cnt, m_la, m_bar;
    logic m_wrap, m_busy;

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_la = 0; m_bar = 0; m_wrap = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic t, input logic [1:0] s);
        m_wrap = 1'b0;
        if (!r) begin
            m_cnt = 0; m_bar = 0; m_busy = 1'b0; m_la = int'(s);
        end else begin
            m_busy = 1'b1;
            if (t) begin
                if (m_cnt + 1 == lens[m_la]) begin
                    m_cnt = 0; m_wrap = 1'b1;
                    m_bar = (m_bar + 1) % 16; m_la = int'(s);
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic t, input logic [1:0] s);
        run = r; tick = t; len_sel = s;
        @(posedge clk);
        model_step(r, t, s);
        #1;
        chk("model_cnt", 32'(cnt), 32'(to_bcd(m_cnt)));
        chk("model_wrap", 32'(wrap), 32'(m_wrap));
        chk("model_bar", 32'(bar), 32'(m_bar));
        chk("model_len_act", 32'(len_act), 32'(m_la));
        chk("model_busy", 32'(busy), 32'(m_busy));
    endtask

    typedef struct {
        logic        run;
        logic        tick;
        logic [1:0]  sel;
        logic [11:0] cnt;
        logic        wrap;
        logic [3:0]  bar;
        logic [1:0]  la;
        logic        busy;
    } vec_t;

    vec_t tab[8];

    initial begin
        tab[0] = '{1'b0, 1'b0, 2'd2, 12'h000, 1'b0, 4'd0, 2'd2, 1'b0};
        tab[1] = '{1'b1, 1'b0, 2'd2, 12'h000, 1'b0, 4'd0, 2'd2, 1'b1};
        tab[2] = '{1'b1, 1'b1, 2'd2, 12'h001, 1'b0, 4'd0, 2'd2, 1'b1};
        tab[3] = '{1'b1, 1'b1, 2'd1, 12'h002, 1'b0, 4'd0, 2'd2, 1'b1};
        tab[4] = '{1'b1, 1'b0, 2'd1, 12'h002, 1'b0, 4'd0, 2'd2, 1'b1};
        tab[5] = '{1'b0, 1'b1, 2'd1, 12'h000, 1'b0, 4'd0, 2'd1, 1'b0};
        tab[6] = '{1'b0, 1'b0, 2'd3, 12'h000, 1'b0, 4'd0, 2'd3, 1'b0};
        tab[7] = '{1'b1, 1'b1, 2'd3, 12'h001, 1'b0, 4'd0, 2'd3, 1'b1};

        rst = 1'b1; tick = 1'b0; run = 1'b0; len_sel = 2'd0; len_sel_b = 2'd3;
        model_reset();
        #12;
        chk("reset_cnt", 32'(cnt), 32'h0);
        chk("reset_len_act", 32'(len_act), 32'h0);
        chk("reset_wrap", 32'(wrap), 32'h0);
        chk("reset_bar", 32'(bar), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_b_cnt", 32'(cnt_b), 32'h0);
        #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            cycle(tab[i].run, tab[i].tick, tab[i].sel);
            chk("tab_cnt", 32'(cnt), 32'(tab[i].cnt));
            chk("tab_wrap", 32'(wrap), 32'(tab[i].wrap));
            chk("tab_bar", 32'(bar), 32'(tab[i].bar));
            chk("tab_len_act", 32'(len_act), 32'(tab[i].la));
            chk("tab_busy", 32'(busy), 32'(tab[i].busy));
        end

        // Default length, ticks separated by idle cycles.
        #2 rst = 1'b1; model_reset();
        #2 rst = 1'b0;
        cycle(1'b1, 1'b0, 2'd0);
        chk("run_rise_busy", 32'(busy), 32'h1);
        for (int i = 1; i <= 125; i++) begin
            cycle(1'b1, 1'b1, 2'd0);
            if (i == 9)   chk("cnt_009", 32'(cnt), 32'h009);
            if (i == 10)  chk("cnt_010", 32'(cnt), 32'h010);
            if (i == 99)  chk("cnt_099", 32'(cnt), 32'h099);
            if (i == 100) chk("carry_100", 32'(cnt), 32'h100);
            if (i == 124) chk("cnt_124", 32'(cnt), 32'h124);
            if (i < 125)  chk("no_wrap", 32'(wrap), 32'h0);
            if (i == 125) begin
                chk("wrap125_cnt", 32'(cnt), 32'h000);
                chk("wrap125_pulse", 32'(wrap), 32'h1);
                chk("wrap125_bar", 32'(bar), 32'h1);
            end
            cycle(1'b1, 1'b0, 2'd0);
        end
        chk("wrap_one_cycle", 32'(wrap), 32'h0);

        // Deferred length change requested at 060.
        for (int i = 0; i < 60; i++) cycle(1'b1, 1'b1, 2'd0);
        chk("defer_at_060", 32'(cnt), 32'h060);
        for (int i = 0; i < 64; i++) cycle(1'b1, 1'b1, 2'd3);
        chk("defer_reach_124", 32'(cnt), 32'h124);
        chk("defer_len_held", 32'(len_act), 32'h0);
        cycle(1'b1, 1'b1, 2'd3);
        chk("defer_wrap", 32'(wrap), 32'h1);
        chk("defer_len_new", 32'(len_act), 32'h3);
        for (int i = 0; i < 24; i++) cycle(1'b1, 1'b1, 2'd3);
        chk("len3_at_024", 32'(cnt), 32'h024);
        chk("len3_no_wrap", 32'(wrap), 32'h0);
        cycle(1'b1, 1'b1, 2'd3);
        chk("len3_wrap", 32'(wrap), 32'h1);
        chk("len3_bar", 32'(bar), 32'h3);

        // Stop on the terminal tick: no wrap is produced.
        for (int i = 0; i < 25; i++) cycle(1'b1, 1'b1, 2'd0);
        chk("back_len0", 32'(len_act), 32'h0);
        for (int i = 0; i < 124; i++) cycle(1'b1, 1'b1, 2'd0);
        chk("stop_pre_124", 32'(cnt), 32'h124);
        cycle(1'b0, 1'b1, 2'd0);
        chk("stop_cnt", 32'(cnt), 32'h000);
        chk("stop_wrap", 32'(wrap), 32'h0);
        chk("stop_bar", 32'(bar), 32'h0);
        chk("stop_busy", 32'(busy), 32'h0);
        cycle(1'b0, 1'b0, 2'd2);
        chk("stop_len_follow2", 32'(len_act), 32'h2);
        cycle(1'b0, 1'b0, 2'd1);
        chk("stop_len_follow1", 32'(len_act), 32'h1);

        // Length of one on the second instance: wrap on every tick.
        for (int i = 1; i <= 17; i++) begin
            cycle(1'b1, 1'b1, 2'd1);
            chk("bar_b_wrap", 32'(wrap_b), 32'h1);
            chk("bar_b_bar", 32'(bar_b), 32'(i % 16));
            chk("bar_b_cnt", 32'(cnt_b), 32'h000);
        end

        // Asynchronous reset between edges at cnt=073, bar=2.
        cycle(1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 323; i++) cycle(1'b1, 1'b1, 2'd0);
        chk("pre_rst_cnt", 32'(cnt), 32'h073);
        chk("pre_rst_bar", 32'(bar), 32'h2);
        #2 rst = 1'b1;
        #1;
        chk("arst_cnt", 32'(cnt), 32'h0);
        chk("arst_bar", 32'(bar), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_len_act", 32'(len_act), 32'h0);
        chk("arst_wrap", 32'(wrap), 32'h0);
        chk("arst_b_bar", 32'(bar_b), 32'h0);
        model_reset();
        #1 rst = 1'b0;
        cycle(1'b1, 1'b1, 2'd0);
        chk("restart_001", 32'(cnt), 32'h001);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
